// File: rtl/wrr_lock_arbiter_if.sv
// Handshake bundle between N requesters, the weighted lock arbiter and the downstream port.
// lock_timeout exists only when WRR_LOCK_TIMEOUT_EN is defined.
interface wrr_lock_arbiter_if #(
    parameter int unsigned N        = 8,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]          req;
    logic [N-1:0]          req_last;
    logic [N*WEIGHT_W-1:0] weight;
    logic                  out_ready;
    logic [N-1:0]          gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_valid;
    logic                  locked;
`ifdef WRR_LOCK_TIMEOUT_EN
    logic                  lock_timeout;
`endif

    modport master (
`ifdef WRR_LOCK_TIMEOUT_EN
        input  lock_timeout,
`endif
        output req, req_last, weight, out_ready,
        input  gnt, gnt_idx, gnt_valid, locked
    );

    modport slave (
`ifdef WRR_LOCK_TIMEOUT_EN
        output lock_timeout,
`endif
        input  req, req_last, weight, out_ready,
        output gnt, gnt_idx, gnt_valid, locked
    );
endinterface

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with per-packet grant lock onto one valid/ready port.
// Optional forced lock release after LOCK_TO idle locked cycles: define WRR_LOCK_TIMEOUT_EN.
module wrr_lock_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1,
    parameter int unsigned LOCK_TO  = 64
) (
    input logic               clk,
    input logic               rst_n,
    wrr_lock_arbiter_if.slave bus
);

    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                lock_q, lock_d;
    logic [WEIGHT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [N-1:0]        gnt_raw;
    logic [IDX_W-1:0]    gnt_sel;
    logic [IDX_W-1:0]    scan_idx;
    logic                found;
    logic                accept;
    logic                owner_drop;
    logic                force_release;
    logic [WEIGHT_W-1:0] weight_g;
    logic [WEIGHT_W:0]   weight_eff;
    logic [WEIGHT_W:0]   pkt_num;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (32'(idx) >= N - 1) ? '0 : idx + 1'b1;
    endfunction

    // Grant path: owner only while locked, otherwise first requester at or after ptr.
    always_comb begin
        gnt_raw  = '0;
        gnt_sel  = '0;
        found    = 1'b0;
        scan_idx = '0;
        if (lock_q) begin
            if (bus.req[owner_q]) begin
                gnt_raw[owner_q] = 1'b1;
                gnt_sel          = owner_q;
            end
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                scan_idx = IDX_W'((int'(ptr_q) + k) % int'(N));
                if (!found && bus.req[scan_idx]) begin
                    found             = 1'b1;
                    gnt_sel           = scan_idx;
                    gnt_raw[scan_idx] = 1'b1;
                end
            end
        end
        // Outputs must read zero for the whole reset assertion, not just after the next edge.
        if (!rst_n) begin
            gnt_raw = '0;
            gnt_sel = '0;
        end
    end

    assign accept     = (|gnt_raw) && bus.out_ready;
    assign owner_drop = lock_q && !bus.req[owner_q];
    assign weight_g   = bus.weight[32'(gnt_sel) * WEIGHT_W +: WEIGHT_W];
    assign weight_eff = (weight_g == '0) ? (WEIGHT_W + 1)'(1) : {1'b0, weight_g};
    assign pkt_num    = ((gnt_sel == owner_q) ? {1'b0, pkt_cnt_q} : '0) + 1'b1;

`ifdef WRR_LOCK_TIMEOUT_EN
    localparam int unsigned ToCntW = $clog2(LOCK_TO + 1);

    logic [ToCntW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!lock_q || accept) begin
            to_cnt_d = '0;
        end else if (32'(to_cnt_q) < LOCK_TO) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign force_release    = lock_q && !accept && !owner_drop && (32'(to_cnt_q) >= LOCK_TO);
    assign bus.lock_timeout = force_release;
`else
    logic unused_lock_to;

    assign unused_lock_to = ^LOCK_TO;
    assign force_release  = 1'b0;
`endif

    always_comb begin
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        lock_d    = lock_q;
        pkt_cnt_d = pkt_cnt_q;
        if (accept) begin
            owner_d = gnt_sel;
            if (!bus.req_last[gnt_sel]) begin
                lock_d = 1'b1;
                if (gnt_sel != owner_q) begin
                    pkt_cnt_d = '0;
                end
            end else begin
                lock_d = 1'b0;
                if (pkt_num >= weight_eff) begin
                    ptr_d     = next_idx(gnt_sel);
                    pkt_cnt_d = '0;
                end else begin
                    // Turn not used up: the owner keeps top priority for its next packet.
                    ptr_d     = gnt_sel;
                    pkt_cnt_d = pkt_num[WEIGHT_W-1:0];
                end
            end
        end else if (owner_drop || force_release) begin
            lock_d    = 1'b0;
            ptr_d     = next_idx(owner_q);
            pkt_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            lock_q    <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            lock_q    <= lock_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign bus.gnt       = gnt_raw;
    assign bus.gnt_idx   = gnt_sel;
    assign bus.gnt_valid = |gnt_raw;
    assign bus.locked    = lock_q;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Scoreboard bench for wrr_lock_arbiter: directed sequences plus randomized packet traffic
// checked against a turn-based reference model.
module tb_wrr_lock_arbiter;
    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IW = 2;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wrr_lock_arbiter_if #(.N(N), .WEIGHT_W(WW), .IDX_W(IW)) bus ();

    wrr_lock_arbiter #(.N(N), .WEIGHT_W(WW), .IDX_W(IW), .LOCK_TO(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0]  gnt;
        logic [IW-1:0] idx;
        logic          valid;
        logic          locked;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    event chk_ev;
    int   tests = 0;
    int   fails = 0;

    // Reference model: who holds priority, who is mid-packet, packets spent in the current turn.
    int   m_ptr;
    int   m_owner;
    int   m_cnt;
    bit   m_lock;
    int   weights[N];

    task automatic check(input string name, input string tag, input logic [31:0] act,
                         input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s (%s) at %0t: got %0h required %0h", name, tag, $time, act, want);
        end
    endtask

    always begin
        @(negedge clk or chk_ev);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("gnt", mon_e.tag, 32'(bus.gnt), 32'(mon_e.gnt));
            check("gnt_idx", mon_e.tag, 32'(bus.gnt_idx), 32'(mon_e.idx));
            check("gnt_valid", mon_e.tag, 32'(bus.gnt_valid), 32'(mon_e.valid));
            check("locked", mon_e.tag, 32'(bus.locked), 32'(mon_e.locked));
        end
    end

    function automatic void model_reset();
        m_ptr   = 0;
        m_owner = 0;
        m_cnt   = 0;
        m_lock  = 1'b0;
    endfunction

    function automatic int model_grant(input logic [N-1:0] r);
        if (m_lock) return r[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_update(input int g, input logic [N-1:0] r,
                                         input logic [N-1:0] rl, input logic rdy);
        int w;
        int n;
        if (g >= 0 && rdy) begin
            if (!rl[g]) begin
                if (g != m_owner) m_cnt = 0;
                m_lock  = 1'b1;
                m_owner = g;
            end else begin
                n       = ((g == m_owner) ? m_cnt : 0) + 1;
                w       = (weights[g] == 0) ? 1 : weights[g];
                m_lock  = 1'b0;
                m_owner = g;
                if (n >= w) begin
                    m_ptr = (g + 1) % N;
                    m_cnt = 0;
                end else begin
                    m_ptr = g;
                    m_cnt = n;
                end
            end
        end else if (m_lock && !r[m_owner]) begin
            m_lock = 1'b0;
            m_ptr  = (m_owner + 1) % N;
            m_cnt  = 0;
        end
    endfunction

    // One clock of stimulus; want >= 0 replaces the model's grant with a fixed unlocked grant.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] rl, input logic rdy,
                        input string tag, input int want, output int g);
        exp_t e;
        bus.req       = r;
        bus.req_last  = rl;
        bus.out_ready = rdy;
        for (int i = 0; i < N; i++) bus.weight[i*WW +: WW] = WW'(weights[i]);
        g        = model_grant(r);
        e.valid  = (g >= 0);
        e.gnt    = e.valid ? (N'(1) << g) : '0;
        e.idx    = e.valid ? IW'(g) : '0;
        e.locked = m_lock;
        e.tag    = tag;
        if (want >= 0) begin
            e.valid  = 1'b1;
            e.gnt    = N'(1) << want;
            e.idx    = IW'(want);
            e.locked = 1'b0;
        end
        exp_q.push_back(e);
        model_update(g, r, rl, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic push_zero(input string tag);
        exp_t e;
        e.gnt    = '0;
        e.idx    = '0;
        e.valid  = 1'b0;
        e.locked = 1'b0;
        e.tag    = tag;
        exp_q.push_back(e);
        -> chk_ev;
        #1;
    endtask

    task automatic rand_phase(input int cycles, input int p_new, input int max_len,
                              input int p_rdy, input int p_drop);
        int           beats[N];
        logic [N-1:0] r;
        logic [N-1:0] rl;
        logic         rdy;
        int           g;
        for (int i = 0; i < N; i++) beats[i] = 0;
        repeat (cycles) begin
            for (int i = 0; i < N; i++) begin
                if (beats[i] == 0 && int'($urandom_range(99)) < p_new)
                    beats[i] = int'($urandom_range(max_len, 1));
                r[i]  = (beats[i] > 0);
                rl[i] = (beats[i] == 1);
            end
            if (m_lock && beats[m_owner] > 0 && int'($urandom_range(99)) < p_drop) begin
                r[m_owner]     = 1'b0;
                rl[m_owner]    = 1'b0;
                beats[m_owner] = 0;
            end
            rdy = (int'($urandom_range(99)) < p_rdy);
            step(r, rl, rdy, "rand", -1, g);
            if (g >= 0 && rdy) beats[g]--;
        end
    endtask

    initial begin
        int g;
        int wseq[8];
        wseq = '{0, 3, 3, 3, 0, 3, 3, 3};
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_last  = '0;
        bus.out_ready = 1'b0;
        bus.weight    = '0;
        for (int i = 0; i < N; i++) weights[i] = 1;
        model_reset();

        #12;
        bus.req       = '1;
        bus.req_last  = '1;
        bus.out_ready = 1'b1;
        push_zero("in_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) step(4'b1111, 4'b1111, 1'b1, "rotation", k % 4, g);

        weights[3] = 3;
        for (int k = 0; k < 8; k++) step(4'b1001, 4'b1001, 1'b1, "weighting", wseq[k], g);
        weights[3] = 1;

        step(4'b0011, 4'b0000, 1'b1, "lock_b1", -1, g);
        step(4'b0011, 4'b0000, 1'b1, "lock_b2", -1, g);
        step(4'b0011, 4'b0001, 1'b1, "lock_b3", -1, g);
        step(4'b0010, 4'b0010, 1'b1, "lock_next", 1, g);

        step(4'b0100, 4'b0000, 1'b1, "bp_start", -1, g);
        repeat (5) step(4'b0111, 4'b0000, 1'b0, "bp_hold", -1, g);
        step(4'b0111, 4'b0100, 1'b1, "bp_end", -1, g);
        step(4'b0011, 4'b0011, 1'b1, "bp_after", -1, g);

        step(4'b0010, 4'b0000, 1'b1, "drop_lock", 1, g);
        step(4'b0110, 4'b0000, 1'b1, "drop_held", -1, g);
        step(4'b0100, 4'b0000, 1'b1, "drop", -1, g);
        step(4'b1101, 4'b1111, 1'b1, "drop_next", 2, g);

        step(4'b0010, 4'b0000, 1'b1, "rst_lock", 1, g);
        step(4'b1111, 4'b0000, 1'b1, "rst_held", -1, g);
        #2;
        rst_n = 1'b0;
        #1;
        push_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1111, 4'b1111, 1'b1, "after_reset", 0, g);

        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < N; i++) weights[i] = int'($urandom_range(4));
            rand_phase(400, int'($urandom_range(90, 20)), int'($urandom_range(4, 1)),
                       int'($urandom_range(100, 40)), int'($urandom_range(5)));
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wrr_lock_arbiter.md
Name: wrr_lock_arbiter

Overview:
- Parametrised weighted round-robin arbiter for the attention-score datapath. It arbitrates N requesters onto one shared downstream port using a valid/ready handshake.
- Supports multi-beat packets: the grant locks to the owner until its last beat is accepted.
- Each requester gets a per-requester weight: up to WEIGHT[i] consecutive packets before priority rotates.
- Successor to the single-cycle RR arbiter.

Parameters:
- N, 8, number of requesters (N>=1).
- WEIGHT_W, 4, width of each weight field.
- IDX_W, $clog2(N) (min 1), width of gnt_idx.
- LOCK_TO, 64, lock-timeout cycle count; used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N  per-requester valid; a requester holds it high until its beat is accepted.
- req_last  input  N  per-requester last-beat flag; meaningful only with req.
- weight  input  N*WEIGHT_W  packets per turn; field i = weight[i*WEIGHT_W +: WEIGHT_W]; 0 is treated as 1; quasi-static.
- out_ready  input  1  downstream ready.
- gnt  output  N  one-hot grant; zero when nothing is granted.
- gnt_idx  output  IDX_W  binary index of gnt; 0 when gnt_valid=0.
- gnt_valid  output  1  equals |gnt.
- locked  output  1  arbiter is mid-packet.

Behaviour:
- State registers:
  - ptr (IDX_W), the highest-priority index.
  - owner (IDX_W).
  - lock (1).
  - pkt_cnt (WEIGHT_W), packets completed by owner in the current turn.
- Reset values: ptr=0, owner=0, lock=0, pkt_cnt=0. While rst_n=0, gnt=0, gnt_idx=0, gnt_valid=0, locked=0.
- Grant is combinational from state and req; there is zero-cycle latency from req to gnt.
  - UNLOCKED: grant the first i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. If req=0, then gnt=0.
  - LOCKED: gnt = onehot(owner) & req. Non-owner requests are ignored.
- A beat is accepted when gnt_valid && out_ready. Define g as the granted index.
- On an accepted beat with req_last[g]=0: lock<=1 and owner<=g. If g differs from the previous owner, pkt_cnt<=0.
- On an accepted beat with req_last[g]=1 (packet end): lock<=0 and owner<=g. Compute n = (g==owner ? pkt_cnt : 0) + 1.
  - If n >= max(weight[g],1): ptr <= (g+1) mod N and pkt_cnt<=0.
  - Otherwise: ptr<=g and pkt_cnt<=n, so g keeps priority for its next packet.
- A single-beat packet (req_last=1 on the first beat) never asserts locked.
- Wrap-around: ptr advances N-1 -> 0.
- Owner drops req while LOCKED (protocol violation):
  - gnt=0 that cycle.
  - Next clock: lock<=0, ptr <= (owner+1) mod N, pkt_cnt<=0.
- If out_ready=0, all state holds and gnt stays stable while req is unchanged.
- N=1: ptr is always 0; the weight only affects pkt_cnt.
- Mid-operation reset clears the lock immediately (asynchronously); the next grant starts from index 0.
- Weight changes take effect at the next packet-end comparison.

Optional Feature:
- Macro: WRR_LOCK_TIMEOUT_EN.
- When defined:
  - A counter tracks consecutive LOCKED cycles with no accepted beat.
  - When it reaches LOCK_TO, the next clock does lock<=0, ptr <= (owner+1) mod N, pkt_cnt<=0. This is a forced release.
  - An extra output port, lock_timeout (1), pulses high for one cycle coincident with the release.
  - The counter resets on any accept and whenever unlocked.
- When undefined: no counter and no lock_timeout port; a lock is held indefinitely.

Test Plan:
- Basic rotation: N=4, all weight=1, req=4'b1111 with req_last=1111 and out_ready=1 held. Expect gnt_idx sequence 0,1,2,3,0,1 and locked=0 throughout.
- Weighting: weight={1,1,1,3} (req3 weight 3), req=4'b1001, all single-beat. Expect gnt_idx 0,3,3,3,0,3,3,3.
- Lock: req0 sends 3 beats (last on beat 3) while req1 is also high, out_ready=1.
  - Expect gnt=0001 for 3 cycles, locked=1 after beat 1 until beat 3, then gnt=0010.
- Backpressure: during a req2 packet, out_ready=0 for 5 cycles.
  - Expect gnt=0100 held stable and ptr/pkt_cnt unchanged.
  - Grant continues after out_ready returns.
- Owner drop and reset: req1 locked, req1 drops mid-packet. Expect gnt=0, then the next cycle grants from index 2. Assert rst_n low mid-lock: outputs go to 0 immediately, and after release req=1111 grants index 0.
- Timeout (WRR_LOCK_TIMEOUT_EN, LOCK_TO=8): owner locked with out_ready=0 for 8 cycles.
  - Expect a lock_timeout pulse and locked=0.
  - The next grant is to (owner+1) mod N.
